// File: rtl/char_tracker.sv
// Eight-slot falling-character tracker: inserts descriptors, advances rows once per tick by sweeping
// all slots, and retires characters that reach ROW_LIMIT. Define CHAR_KILL_EN to add the kill port.
module char_tracker #(
  parameter int unsigned ROW_LIMIT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_valid,
  input  logic [23:0] new_ch,
  output logic        new_ready,
  input  logic        tick,
  input  logic [2:0]  rd_idx,
  output logic [23:0] rd_ch,
  output logic        busy,
  output logic [3:0]  active_cnt,
  output logic [7:0]  miss_cnt,
`ifdef CHAR_KILL_EN
  input  logic        kill_valid,
  input  logic [9:0]  kill_x,
  output logic [7:0]  hit_cnt,
`endif
  output logic        overrun
);

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam logic [9:0] ROW_LIM = 10'(ROW_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] slots_q [8];
  logic [23:0] slots_d [8];
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  act_q, act_d;
  logic [7:0]  miss_q, miss_d;
`ifdef CHAR_KILL_EN
  logic [7:0]  hit_q, hit_d;
`endif

  logic        free_found;
  logic [2:0]  free_idx;
  logic [9:0]  sum;
  logic        ins, ret, kil;

  // Scanning from the top down leaves the lowest-index free slot selected.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!slots_q[i][23]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

`ifdef CHAR_KILL_EN
  logic       kill_found;
  logic [2:0] kill_idx;

  always_comb begin
    kill_found = 1'b0;
    kill_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (slots_q[i][23] && (slots_q[i][9:0] == kill_x)) begin
        kill_found = 1'b1;
        kill_idx   = 3'(i);
      end
    end
  end
`endif

  // New row of the slot under the sweep index; 10 bits so the overflow past row 511 is kept.
  assign sum = {1'b0, slots_q[idx_q][18:10]} + {6'd0, slots_q[idx_q][22:19]} + 10'd1;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    miss_d  = miss_q;
    for (int i = 0; i < 8; i++) slots_d[i] = slots_q[i];
    ins = 1'b0;
    ret = 1'b0;
    kil = 1'b0;
`ifdef CHAR_KILL_EN
    hit_d = hit_q;
`endif

    if (tick && pend_q) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = SWEEP;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
        end
        if (new_valid && free_found && new_ch[23]) begin
          slots_d[free_idx] = new_ch;
          ins = 1'b1;
        end
`ifdef CHAR_KILL_EN
        // The inserted slot was free this cycle, so it can never be the kill target.
        if (kill_valid && kill_found) begin
          slots_d[kill_idx] = 24'd0;
          kil = 1'b1;
          if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
        end
`endif
      end
      SWEEP: begin
        if (tick && !pend_q) pend_d = 1'b1;
        if (slots_q[idx_q][23]) begin
          if (sum >= ROW_LIM) begin
            slots_d[idx_q][23] = 1'b0;
            ret = 1'b1;
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
          end else begin
            slots_d[idx_q][18:10] = sum[8:0];
          end
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    act_d = act_q + 4'(ins) - 4'(ret) - 4'(kil);
  end

  // NOTE: the slot array is reset along with the control state so no stale live bit survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      act_q   <= 4'd0;
      miss_q  <= 8'd0;
      for (int i = 0; i < 8; i++) slots_q[i] <= 24'd0;
`ifdef CHAR_KILL_EN
      hit_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      act_q   <= act_d;
      miss_q  <= miss_d;
      for (int i = 0; i < 8; i++) slots_q[i] <= slots_d[i];
`ifdef CHAR_KILL_EN
      hit_q   <= hit_d;
`endif
    end
  end

  assign new_ready  = (state_q == IDLE) && free_found;
  assign busy       = (state_q == SWEEP);
  assign rd_ch      = slots_q[rd_idx];
  assign active_cnt = act_q;
  assign miss_cnt   = miss_q;
  assign overrun    = ovr_q;
`ifdef CHAR_KILL_EN
  assign hit_cnt    = hit_q;
`endif

endmodule

// File: tb/tb_char_tracker.sv
// Directed self-checking bench for char_tracker; the kill scenario is built when CHAR_KILL_EN is defined.
module tb_char_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_valid;
  logic [23:0] new_ch;
  logic        new_ready;
  logic        tick;
  logic [2:0]  rd_idx;
  logic [23:0] rd_ch;
  logic        busy;
  logic [3:0]  active_cnt;
  logic [7:0]  miss_cnt;
  logic        overrun;
`ifdef CHAR_KILL_EN
  logic        kill_valid;
  logic [9:0]  kill_x;
  logic [7:0]  hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  char_tracker #(.ROW_LIMIT(480)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_valid  (new_valid),
    .new_ch     (new_ch),
    .new_ready  (new_ready),
    .tick       (tick),
    .rd_idx     (rd_idx),
    .rd_ch      (rd_ch),
    .busy       (busy),
    .active_cnt (active_cnt),
    .miss_cnt   (miss_cnt),
`ifdef CHAR_KILL_EN
    .kill_valid (kill_valid),
    .kill_x     (kill_x),
    .hit_cnt    (hit_cnt),
`endif
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input int idx, input logic [23:0] exp);
    rd_idx = 3'(idx);
    #1;
    check(tag, {8'd0, rd_ch}, {8'd0, exp});
  endtask

  task automatic insert(input logic [23:0] ch);
    new_valid = 1'b1;
    new_ch    = ch;
    step();
    new_valid = 1'b0;
    new_ch    = 24'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulses tick once and waits for the sweep, checking it lasts exactly 8 cycles.
  task automatic tick_sweep(input string tag);
    int n;
    tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    check(tag, n, 8);
  endtask

  initial begin
    int sweeps;
    logic prev;
    rst = 1'b1; new_valid = 1'b0; new_ch = 24'd0; tick = 1'b0; rd_idx = 3'd0;
`ifdef CHAR_KILL_EN
    kill_valid = 1'b0; kill_x = 10'd0;
`endif
    step();
    step();
    check("rst_ready", new_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_active", active_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_overrun", overrun, 0);
    check_slot("rst_slot0", 0, 24'd0);
    rst = 1'b0;
    step();

    // Non-live descriptor is ignored.
    insert(24'h000123);
    check("ignore_active", active_cnt, 0);
    check_slot("ignore_slot0", 0, 24'd0);

    // speed 1, row 0, x 100
    insert(24'h880064);
    check_slot("ins_slot0", 0, 24'h880064);
    check("ins_active", active_cnt, 1);
    check("ins_ready", new_ready, 1);

    tick = 1'b1;
    step();
    tick = 1'b0;
    check("sweep_busy", busy, 1);
    check("sweep_ready_low", new_ready, 0);
    begin
      int n;
      n = 1;
      while (busy && n < 20) begin
        step();
        if (busy) n++;
      end
      check("sweep1_len", n, 8);
    end
    check_slot("sweep1_slot0", 0, 24'h880864);
    check("sweep1_miss", miss_cnt, 0);

    // slot1: row 470 speed 15 x 5 retires; slot2: row 478 speed 0 x 7 reaches 479 then 480.
    insert(24'hFF5805);
    insert(24'h877807);
    check("pre_ret_active", active_cnt, 3);
    tick_sweep("sweep2_len");
    check_slot("sweep2_slot0", 0, 24'h881064);
    check_slot("sweep2_slot1", 1, 24'h7F5805);
    check_slot("sweep2_slot2", 2, 24'h877C07);
    check("sweep2_miss", miss_cnt, 1);
    check("sweep2_active", active_cnt, 2);
    tick_sweep("sweep3_len");
    check_slot("sweep3_slot0", 0, 24'h881864);
    check_slot("sweep3_slot2", 2, 24'h077C07);
    check("sweep3_miss", miss_cnt, 2);
    check("sweep3_active", active_cnt, 1);

    // Three consecutive ticks: one runs, one pends, one is lost.
    sweeps = 0;
    prev = busy;
    for (int k = 0; k < 40; k++) begin
      tick = (k < 3);
      step();
      if (busy && !prev) sweeps++;
      prev = busy;
    end
    tick = 1'b0;
    check("ovr_sweeps", sweeps, 2);
    check("ovr_flag", overrun, 1);
    check_slot("ovr_slot0", 0, 24'h882864);

    // Insert and tick in the same idle cycle: the new slot is swept.
    do_reset();
    check("rst2_overrun", overrun, 0);
    check("rst2_miss", miss_cnt, 0);
    new_valid = 1'b1; new_ch = 24'h880001; tick = 1'b1;
    step();
    new_valid = 1'b0; tick = 1'b0;
    while (busy) step();
    check_slot("same_cyc_slot0", 0, 24'h880801);

    // Fill: nine back-to-back offers, only eight accepted.
    do_reset();
    new_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      new_ch = 24'h800000 | 24'(k);
      check($sformatf("fill_ready%0d", k), new_ready, (k < 8) ? 1 : 0);
      step();
    end
    new_valid = 1'b0;
    check("fill_active", active_cnt, 8);
    check("fill_ready_low", new_ready, 0);
    for (int i = 0; i < 8; i++) check_slot($sformatf("fill_slot%0d", i), i, 24'h800000 | 24'(i));

    // Reset in the middle of a sweep aborts it at once.
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_active", active_cnt, 0);
    step();
    rst = 1'b0;
    step();
    check("postrst_ready", new_ready, 1);
    check("postrst_busy", busy, 0);
    check_slot("postrst_slot3", 3, 24'd0);

`ifdef CHAR_KILL_EN
    // Slots 2 and 5 share x 300; kill clears the lower one while an insert lands in slot 6.
    do_reset();
    insert(24'h80000A);
    insert(24'h800014);
    insert(24'h80012C);
    insert(24'h800028);
    insert(24'h800032);
    insert(24'h80012C);
    kill_valid = 1'b1; kill_x = 10'd300;
    new_valid = 1'b1; new_ch = 24'h80003C;
    step();
    kill_valid = 1'b0; new_valid = 1'b0;
    check_slot("kill_slot2", 2, 24'd0);
    check_slot("kill_slot5", 5, 24'h80012C);
    check_slot("kill_slot6", 6, 24'h80003C);
    check("kill_hit", hit_cnt, 1);
    check("kill_active", active_cnt, 6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
